cpu_clk_ctrl: RTL
=================

Name: cpu_clk_ctrl

Overview:
- Parametrised CPU clock/step controller.
- Generates the divided CPU clock from clk50M in four modes: free-run, single-step, N-step burst and halt.
- Debounces the manual step button.
- Produces a stretched CPU reset on system reset or ROM-selector change.
- Sits between the board top level and the system instance and drives its clk_cpu and rst inputs.

Parameters:
- DIV_WIDTH, 25, width of cpu_speed and the divider counter.
- STEP_WIDTH, 8, width of step_count and the pending-period counter.
- DB_WIDTH, 16, width of the debounce counter.
- DB_COUNT, 50000, clk50M cycles clk_manual must stay stable before a level change is accepted; must fit in DB_WIDTH.
- RST_STRETCH, 4, number of clk_cpu rising edges cpu_rst is held after its trigger; must be ≥1.

Ports:
- clk50M  in  1  sole clock; all logic clocked on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  00 free-run, 01 single-step, 10 burst, 11 halt; sampled every cycle.
- cpu_speed  in  DIV_WIDTH  half-period of clk_cpu minus one, in clk50M cycles.
- step_count  in  STEP_WIDTH  periods issued per press in burst mode.
- clk_manual  in  1  raw, asynchronous step button, active high.
- rom_selector  in  1  asynchronous level; any change forces a CPU reset.
- clk_cpu  out  1  registered divided clock.
- tick  out  1  one-cycle pulse, asserted in the same cycle clk_cpu goes 0→1.
- busy  out  1  high while pending periods remain.
- cpu_rst  out  1  reset to the system, active high.

Behaviour:
- Reset values (asynchronous, on rst=1):
  - clk_cpu=0, tick=0, busy=0, cpu_rst=1.
  - Divider count=0, pending=0, debounced level=0, debounce count=0.
  - All sync flops=0.
  - Stretch counter=RST_STRETCH.
- Input synchronisation: clk_manual and rom_selector each pass through 2 flops before use.
- Debounce:
  - The counter clears whenever the synced clk_manual equals the debounced level.
  - Otherwise it increments. On reaching DB_COUNT-1 the debounced level takes the synced value and the counter clears.
  - press = one-cycle pulse on a 0→1 transition of the debounced level.
- Divider:
  - When enabled, the count increments each cycle.
  - When count ≥ cpu_speed: count←0 and clk_cpu toggles. Half-period is therefore cpu_speed+1 cycles; cpu_speed=0 gives 25 MHz.
  - The ≥ compare means lowering cpu_speed below the current count toggles on the next cycle.
  - When disabled, the count is held at 0.
- Enable is true when any of these holds:
  - mode=00;
  - pending≠0;
  - clk_cpu=1, so the current high phase always completes before stopping.
- Step control:
  - press with mode=01 and pending=0 loads pending←1.
  - press with mode=10 and pending=0 loads pending←step_count; step_count=0 gives no effect.
  - press while pending≠0, or in mode 00/11, is ignored.
  - pending decrements on each clk_cpu 1→0 toggle while pending≠0.
  - The first rising edge after press occurs cpu_speed+1 cycles after the press pulse.
- busy = (pending≠0), registered together with pending.
- Mode change mid-burst:
  - To 00 or 11: pending←0 on the next cycle.
  - Under 11, clk_cpu finishes its high phase, then stays low.
  - Between 01 and 10: pending is kept.
- ROM reset:
  - A change of the synced rom_selector versus its previous synced value reloads the stretch counter to RST_STRETCH, in the same cycle the change is detected.
- cpu_rst:
  - Output of a register that is 1 whenever the stretch counter ≠0 or was reloaded this cycle.
  - The stretch counter decrements on each tick cycle, saturating at 0.
  - cpu_rst falls in the cycle after the RST_STRETCH-th tick.
  - A reload during the stretch restarts it.
  - In modes 01/11 cpu_rst stays high until enough step ticks occur; this is intended, since the CPU only sees reset on its own clock edges.
- Simultaneous events:
  - press and a mode change in the same cycle: press is evaluated against the new mode value sampled that cycle.
  - Decrement and load cannot coincide, because load requires pending=0.

Test Plan:
- Reset, mode=00, cpu_speed=3 → clk_cpu period 8 cycles, tick every 8 cycles, cpu_rst falls the cycle after the 4th tick, busy stays 0.
- DB_COUNT=4, mode=01, cpu_speed=2; clk_manual bounces high for 2 cycles, low for 2, three times, then stable high for 20 → exactly one press, one tick, clk_cpu high 3 cycles then low, busy high from the press until the falling edge.
- mode=10, step_count=5, cpu_speed=1 → 5 ticks spaced 4 cycles apart; busy falls on the 5th 1→0 toggle; a second press during the burst adds no ticks; step_count=0 press yields no ticks.
- mode 00→11 while clk_cpu=1 with 2 of 4 high cycles elapsed → clk_cpu falls after 2 more cycles; no further tick for 100 cycles.
- Free-run, cpu_speed=0, rom_selector toggled → cpu_rst high within 3 cycles, held through 4 ticks; a second toggle mid-stretch restarts the count of 4.
- rst asserted mid-burst at pending=3 → same cycle: clk_cpu=0, busy=0, cpu_rst=1, pending=0; after release, no ticks in mode 10 until a new press.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
// CPU clock/step controller: divides clk50M into clk_cpu (free-run, single-step,
// N-step burst or halt), debounces the step button and stretches the CPU reset.
module cpu_clk_ctrl #(
  parameter int DIV_WIDTH   = 25,
  parameter int STEP_WIDTH  = 8,
  parameter int DB_WIDTH    = 16,
  parameter int DB_COUNT    = 50000,
  parameter int RST_STRETCH = 4
) (
  input  logic                  clk50M,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [DIV_WIDTH-1:0]  cpu_speed,
  input  logic [STEP_WIDTH-1:0] step_count,
  input  logic                  clk_manual,
  input  logic                  rom_selector,
  output logic                  clk_cpu,
  output logic                  tick,
  output logic                  busy,
  output logic                  cpu_rst
);

  localparam int RS_W = $clog2(RST_STRETCH + 1);
  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_COUNT - 1);
  localparam logic [RS_W-1:0]     RS_INIT = RS_W'(RST_STRETCH);

  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_STEP  = 2'b01,
    MODE_BURST = 2'b10,
    MODE_HALT  = 2'b11
  } mode_e;

  logic [1:0]            man_sync_q, rom_sync_q;
  logic                  rom_prev_q;
  logic                  db_level_q, db_level_d;
  logic [DB_WIDTH-1:0]   db_cnt_q, db_cnt_d;
  logic                  press_q, press_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic                  clk_cpu_q, clk_cpu_d;
  logic                  tick_q, tick_d;
  logic [STEP_WIDTH-1:0] pend_q, pend_d;
  logic                  busy_q, busy_d;
  logic [RS_W-1:0]       stretch_q, stretch_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  div_en, toggle, rom_change;
  mode_e                 mode_s;

  assign mode_s = mode_e'(mode);

  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    press_d    = 1'b0;
    if (man_sync_q[1] != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = man_sync_q[1];
        press_d    = man_sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // A high phase in progress always runs to completion before the clock stops.
  always_comb begin
    div_en    = (mode_s == MODE_RUN) || (pend_q != '0) || clk_cpu_q;
    toggle    = div_en && (div_cnt_q >= cpu_speed);
    div_cnt_d = '0;
    if (div_en && !toggle) div_cnt_d = div_cnt_q + 1'b1;
    clk_cpu_d = clk_cpu_q ^ toggle;
    tick_d    = toggle && !clk_cpu_q;
  end

  always_comb begin
    pend_d = pend_q;
    unique case (mode_s)
      MODE_RUN, MODE_HALT: pend_d = '0;
      MODE_STEP, MODE_BURST: begin
        if (pend_q != '0) begin
          if (toggle && clk_cpu_q) pend_d = pend_q - 1'b1;
        end else if (press_q) begin
          pend_d = (mode_s == MODE_STEP) ? STEP_WIDTH'(1) : step_count;
        end
      end
    endcase
    busy_d = (pend_d != '0);
  end

  always_comb begin
    rom_change = rom_sync_q[1] ^ rom_prev_q;
    stretch_d  = stretch_q;
    if (rom_change) stretch_d = RS_INIT;
    else if (tick_q && (stretch_q != '0)) stretch_d = stretch_q - 1'b1;
    cpu_rst_d = rom_change || (stretch_d != '0);
  end

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      man_sync_q <= '0;
      rom_sync_q <= '0;
      rom_prev_q <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
      div_cnt_q  <= '0;
      clk_cpu_q  <= 1'b0;
      tick_q     <= 1'b0;
      pend_q     <= '0;
      busy_q     <= 1'b0;
      stretch_q  <= RS_INIT;
      cpu_rst_q  <= 1'b1;
    end else begin
      man_sync_q <= {man_sync_q[0], clk_manual};
      rom_sync_q <= {rom_sync_q[0], rom_selector};
      rom_prev_q <= rom_sync_q[1];
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      div_cnt_q  <= div_cnt_d;
      clk_cpu_q  <= clk_cpu_d;
      tick_q     <= tick_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      stretch_q  <= stretch_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  assign clk_cpu = clk_cpu_q;
  assign tick    = tick_q;
  assign busy    = busy_q;
  assign cpu_rst = cpu_rst_q;

endmodule
